// File: rtl/flags_register.sv
// Condition-code register for the execute stage: masked ALU flag capture, carry
// set/clear, conditional-jump evaluation with flag clear, and an interrupt save stack.
module flags_register #(
    parameter int FLAG_W     = 4,
    parameter int SAVE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLAG_W-1:0] flags_alu,
    input  logic [FLAG_W-1:0] flags_we,
    input  logic              set_c,
    input  logic              clr_c,
    input  logic              jmp_valid,
    input  logic [1:0]        jmp_cond,
    output logic              jmp_taken,
    input  logic              save,
    input  logic              restore,
    input  logic              stall,
    output logic [FLAG_W-1:0] flags,
    output logic              save_empty,
    output logic              save_full,
    output logic              overflow_err
);

    localparam int CNT_W = $clog2(SAVE_DEPTH + 1);
    localparam int IDX_W = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;
    // Only zero/negative/carry are live; every higher bit reads as 0.
    localparam logic [FLAG_W-1:0] LIVE_MASK = FLAG_W'(3'b111);

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [FLAG_W-1:0] stack_q [SAVE_DEPTH];
    logic [FLAG_W-1:0] stack_d [SAVE_DEPTH];
    logic [FLAG_W-1:0] upd;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;

    assign flags        = flags_q;
    assign overflow_err = err_q;
    assign save_empty   = (cnt_q == '0);
    assign save_full    = (cnt_q == CNT_W'(SAVE_DEPTH));

    always_comb begin
        jmp_taken = 1'b0;
        if (jmp_valid) begin
            case (jmp_cond)
                2'b00:   jmp_taken = 1'b1;
                2'b01:   jmp_taken = flags_q[0];
                2'b10:   jmp_taken = flags_q[1];
                default: jmp_taken = flags_q[2];
            endcase
        end
    end

    always_comb begin
        flags_d  = flags_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        stack_d  = stack_q;
        upd      = flags_q;
        top_idx  = IDX_W'(cnt_q - CNT_W'(1));
        push_idx = IDX_W'(cnt_q);
        if (!stall) begin
            if (restore && !save_empty) begin
                flags_d = stack_q[top_idx] & LIVE_MASK;
                cnt_d   = cnt_q - CNT_W'(1);
            end else begin
                upd = (flags_q & ~flags_we) | (flags_alu & flags_we);
                if (set_c) begin
                    upd[2] = 1'b1;
                end else if (clr_c) begin
                    upd[2] = 1'b0;
                end
                // The taken-jump clear is applied last so it beats ALU writes and SETC.
                if (jmp_valid && jmp_taken) begin
                    case (jmp_cond)
                        2'b01:   upd[0] = 1'b0;
                        2'b10:   upd[1] = 1'b0;
                        2'b11:   upd[2] = 1'b0;
                        default: ;
                    endcase
                end
                flags_d = upd & LIVE_MASK;
                if (restore) begin
                    err_d = 1'b1;
                end else if (save) begin
                    if (save_full) begin
                        err_d = 1'b1;
                    end else begin
                        stack_d[push_idx] = flags_q;
                        cnt_d             = cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < SAVE_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int i = 0; i < SAVE_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

endmodule

// File: tb/tb_flags_register.sv
// Directed vector bench for flags_register: table of one-cycle records plus a few
// hand-written multi-cycle sequences.
module tb_flags_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] flags_alu, flags_we;
    logic       set_c, clr_c, jmp_valid, save, restore, stall;
    logic [1:0] jmp_cond;
    logic       jmp_taken;
    logic [3:0] flags;
    logic       save_empty, save_full, overflow_err;

    int total = 0;
    int bad   = 0;

    flags_register #(.FLAG_W(4), .SAVE_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flags_alu(flags_alu), .flags_we(flags_we),
        .set_c(set_c), .clr_c(clr_c), .jmp_valid(jmp_valid), .jmp_cond(jmp_cond),
        .jmp_taken(jmp_taken), .save(save), .restore(restore), .stall(stall),
        .flags(flags), .save_empty(save_empty), .save_full(save_full),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] alu;
        logic [3:0] we;
        logic       setc;
        logic       clrc;
        logic       jv;
        logic [1:0] cond;
        logic       save;
        logic       rest;
        logic       stall;
        logic       exp_jt;
        logic [3:0] exp_flags;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] alu, input logic [3:0] we,
                       input logic sc, input logic cc, input logic jv, input logic [1:0] cond,
                       input logic sv, input logic rs, input logic st,
                       input logic jt, input logic [3:0] ef, input logic ee,
                       input logic efu, input logic er);
        vec_t v;
        v.rst = r; v.alu = alu; v.we = we; v.setc = sc; v.clrc = cc; v.jv = jv;
        v.cond = cond; v.save = sv; v.rest = rs; v.stall = st; v.exp_jt = jt;
        v.exp_flags = ef; v.exp_empty = ee; v.exp_full = efu; v.exp_err = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; jmp_taken is sampled before the rising
    // edge, registered outputs 1 time unit after it.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; flags_alu = v.alu; flags_we = v.we; set_c = v.setc; clr_c = v.clrc;
        jmp_valid = v.jv; jmp_cond = v.cond; save = v.save; restore = v.rest; stall = v.stall;
        #1;
        chk($sformatf("v%0d jmp_taken", idx), {3'b000, jmp_taken}, {3'b000, v.exp_jt});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d flags", idx), flags, v.exp_flags);
        chk($sformatf("v%0d save_empty", idx), {3'b000, save_empty}, {3'b000, v.exp_empty});
        chk($sformatf("v%0d save_full", idx), {3'b000, save_full}, {3'b000, v.exp_full});
        chk($sformatf("v%0d overflow_err", idx), {3'b000, overflow_err}, {3'b000, v.exp_err});
    endtask

    initial begin
        rst = 1'b1; flags_alu = '0; flags_we = '0; set_c = 0; clr_c = 0;
        jmp_valid = 0; jmp_cond = 2'b00; save = 0; restore = 0; stall = 0;

        //   rst alu      we       sc cc jv cond   sv rs st  jt ef       ee fu er
        add(1, 4'b0000, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0000, 1, 0, 0); // 0 reset
        add(0, 4'b0101, 4'b0111, 0, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0101, 1, 0, 0); // 1 masked write
        add(0, 4'b1111, 4'b1111, 0, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0111, 1, 0, 0); // 2 bit3 stays 0
        add(0, 4'b0001, 4'b0111, 0, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0001, 1, 0, 0); // 3
        add(0, 4'b0000, 4'b0000, 0, 0, 1, 2'b01, 0, 0, 0,  1, 4'b0000, 1, 0, 0); // 4 JZ taken clears Z
        add(0, 4'b0001, 4'b1111, 0, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0001, 1, 0, 0); // 5
        add(0, 4'b0000, 4'b0000, 0, 0, 1, 2'b10, 0, 0, 0,  0, 4'b0001, 1, 0, 0); // 6 JN not taken
        add(0, 4'b0000, 4'b1111, 0, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0000, 1, 0, 0); // 7
        add(0, 4'b0000, 4'b0000, 1, 1, 0, 2'b00, 0, 0, 0,  0, 4'b0100, 1, 0, 0); // 8 set_c wins
        add(0, 4'b0000, 4'b0000, 0, 1, 0, 2'b00, 0, 0, 0,  0, 4'b0000, 1, 0, 0); // 9 clr_c
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0100, 1, 0, 0); // 10 set_c
        add(0, 4'b0100, 4'b0100, 0, 0, 1, 2'b11, 0, 0, 0,  1, 4'b0000, 1, 0, 0); // 11 JC clear beats ALU C
        add(0, 4'b0000, 4'b0000, 0, 0, 1, 2'b00, 0, 0, 0,  1, 4'b0000, 1, 0, 0); // 12 unconditional
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'b01, 0, 0, 0,  0, 4'b0000, 1, 0, 0); // 13 jmp_valid low
        add(0, 4'b0011, 4'b1111, 0, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0011, 1, 0, 0); // 14
        add(0, 4'b0100, 4'b1111, 0, 0, 0, 2'b00, 1, 0, 0,  0, 4'b0100, 0, 0, 0); // 15 push 0011
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'b00, 1, 0, 0,  0, 4'b0100, 0, 1, 0); // 16 push 0100
        add(0, 4'b0001, 4'b0001, 0, 0, 0, 2'b00, 1, 0, 0,  0, 4'b0101, 0, 1, 1); // 17 save while full
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 2'b00, 0, 1, 0,  0, 4'b0100, 0, 0, 1); // 18 pop 0100
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'b00, 0, 1, 0,  0, 4'b0011, 1, 0, 1); // 19 pop 0011
        add(0, 4'b0010, 4'b0111, 0, 0, 0, 2'b00, 0, 1, 0,  0, 4'b0010, 1, 0, 1); // 20 restore empty
        add(0, 4'b0101, 4'b0111, 1, 0, 1, 2'b10, 1, 0, 1,  1, 4'b0010, 1, 0, 1); // 21 stall holds
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'b00, 1, 0, 0,  0, 4'b0010, 0, 0, 1); // 22 push 0010
        add(0, 4'b0001, 4'b1111, 0, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0001, 0, 0, 1); // 23
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'b00, 1, 1, 0,  0, 4'b0010, 1, 0, 1); // 24 save+restore
        add(1, 4'b0000, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0000, 1, 0, 0); // 25 reset clears err
        add(0, 4'b0111, 4'b0111, 0, 0, 0, 2'b00, 0, 0, 0,  0, 4'b0111, 1, 0, 0); // 26
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'b00, 1, 0, 0,  0, 4'b0111, 0, 0, 0); // 27 push 0111
        add(1, 4'b1111, 4'b1111, 1, 0, 0, 2'b00, 1, 0, 1,  0, 4'b0000, 1, 0, 0); // 28 rst over stall/save

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Sequence A: stall masks restore-empty error, then it fires once released.
        @(negedge clk);
        rst = 0; flags_alu = 4'b0011; flags_we = 4'b0011; set_c = 0; clr_c = 0;
        jmp_valid = 0; jmp_cond = 2'b00; save = 0; restore = 1; stall = 1;
        @(posedge clk); #1;
        chk("seqA stalled err", {3'b000, overflow_err}, 4'b0000);
        chk("seqA stalled flags", flags, 4'b0000);
        @(negedge clk);
        stall = 0;
        @(posedge clk); #1;
        chk("seqA restore-empty err", {3'b000, overflow_err}, 4'b0001);
        chk("seqA restore-empty flags", flags, 4'b0011);

        // Sequence B: LIFO order with a stalled pop in the middle; JN on restored value.
        @(negedge clk);
        restore = 0; save = 1; flags_we = 4'b1111; flags_alu = 4'b0010;
        @(posedge clk);                       // push 0011, flags -> 0010
        @(negedge clk);
        save = 1; flags_alu = 4'b0000;
        @(posedge clk); #1;                   // push 0010, flags -> 0000
        chk("seqB full", {3'b000, save_full}, 4'b0001);
        @(negedge clk);
        save = 0; restore = 1; stall = 1; flags_we = 4'b0000;
        @(posedge clk); #1;
        chk("seqB stalled pop flags", flags, 4'b0000);
        chk("seqB stalled pop full", {3'b000, save_full}, 4'b0001);
        @(negedge clk);
        stall = 0;
        @(posedge clk); #1;
        chk("seqB pop1", flags, 4'b0010);
        @(negedge clk);
        restore = 0; jmp_valid = 1; jmp_cond = 2'b10;
        #1;
        chk("seqB JN taken", {3'b000, jmp_taken}, 4'b0001);
        @(posedge clk); #1;
        chk("seqB JN clears N", flags, 4'b0000);
        @(negedge clk);
        jmp_valid = 0; restore = 1;
        @(posedge clk); #1;
        chk("seqB pop2", flags, 4'b0011);
        chk("seqB empty", {3'b000, save_empty}, 4'b0001);

        @(negedge clk);
        restore = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flags_register.md
Name: flags_register

Overview:
- Condition-code register (CCR) sitting directly downstream of the 16-bit ALU in the execute stage.
- Latches the ALU `flags_out` under a per-bit write mask and feeds the registered value back to the ALU `flags_in`.
- Evaluates conditional jumps (JZ/JN/JC) and clears the tested flag when a jump is taken.
- Provides a small save stack so interrupt entry/RTI can preserve and restore flags.

Parameters:
- FLAG_W, 4, CCR width. Bit 0 = zero, bit 1 = negative, bit 2 = carry, bit 3 = reserved (always 0).
- SAVE_DEPTH, 2, number of entries in the interrupt save stack (minimum 1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- flags_alu  in  FLAG_W  ALU `flags_out` for the instruction in execute
- flags_we  in  FLAG_W  per-bit write mask for flags_alu
- set_c  in  1  SETC: force carry to 1
- clr_c  in  1  CLRC: force carry to 0
- jmp_valid  in  1  jump instruction present in execute
- jmp_cond  in  2  00 unconditional, 01 JZ, 10 JN, 11 JC
- jmp_taken  out  1  combinational jump decision
- save  in  1  interrupt entry: push the current CCR
- restore  in  1  RTI: pop into the CCR
- stall  in  1  pipeline stall: hold all state
- flags  out  FLAG_W  registered CCR; drives ALU `flags_in`
- save_empty  out  1  stack holds 0 entries
- save_full  out  1  stack holds SAVE_DEPTH entries
- overflow_err  out  1  sticky error flag

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset: flags=0, stack count=0, overflow_err=0, save_empty=1, save_full=0. Reset overrides every other input, including mid-stall and mid-save.
- jmp_taken is combinational from the registered flags:
  - jmp_valid=0 gives 0.
  - cond 00 gives 1.
  - cond 01/10/11 gives flags[0]/flags[1]/flags[2].
  - jmp_taken is computed even during stall.
- stall=1: flags, stack and overflow_err all hold. No clear, push or pop occurs.
- When stall=0, the next CCR is computed in this priority order:
  1. restore=1 and stack not empty: CCR takes the top entry, count decrements. All other CCR sources are ignored this cycle.
  2. Otherwise, start from the current flags:
     - a. Apply flags_alu on bits where flags_we=1.
     - b. If set_c=1, carry=1. Else if clr_c=1, carry=0. set_c wins when both are asserted.
     - c. If jmp_valid=1, cond≠00 and jmp_taken=1, clear the tested flag. This clear wins over a same-cycle ALU write or set_c to that bit.
- Bit 3 always reads 0, regardless of flags_we or a restored value.
- Save stack is LIFO:
  - save=1 pushes the current registered flags (pre-update value), count increments.
  - save and restore in the same cycle: restore is performed, save is ignored, no error.
  - save while full: no push, overflow_err←1.
  - restore while empty: no pop, normal update path (step 2) applies, overflow_err←1.
- overflow_err clears only on rst.
- save_empty and save_full are decoded combinationally from the registered count.
- Latency: one cycle from any input to flags; zero cycles from flags to jmp_taken.

Test Plan:
- Reset, then flags_alu=4'b0101, we=4'b0111 → flags=4'b0101 next cycle. Bit 3 stays 0 with flags_alu=4'b1111, we=4'b1111.
- flags=4'b0001, jmp_valid=1, cond=01 → jmp_taken=1 same cycle, flags=4'b0000 next cycle. Repeat with cond=10 → jmp_taken=0, flags unchanged.
- flags=4'b0000: set_c=1, clr_c=1 → flags=4'b0100. Then clr_c=1 → 4'b0000. Then JC with flags_alu carry=1, we=4'b0100 in the same cycle as a taken JC from flags=4'b0100 → carry cleared, flags=4'b0000.
- Push 4'b0011 then 4'b0100 (save_full=1). Third save → overflow_err=1, count stays 2. Restore twice → flags 4'b0100 then 4'b0011, save_empty=1. Third restore → overflow_err stays 1, flags follow the ALU write path.
- stall=1 with we=4'b0111, set_c=1, save=1 → no change to flags, count or error. jmp_taken still reflects flags.
- Assert rst mid-sequence with count=1, flags=4'b0111 → flags=0, save_empty=1, overflow_err=0 on the next edge.
